// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: state encoding,
// datapath widths, the NOP bubble word and the PC step.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [PC_W-1:0]    PC_INC    = 16'd2;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUF  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Sequential PC, wrapping modulo 2^16.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/ifetch_redirect_if.sv
// Instruction memory request/response bus: one outstanding request,
// completion signalled by imem_rvalid while imem_req is high.
interface ifetch_redirect_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register that catches a fetch completing
// while IF/ID is stalled.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ifetch_redirect.sv
// Fetch stage front end: PC, single-outstanding imem requests, IF/ID register
// with skid buffer, redirect flush with stale-response drop, and halt.
module ifetch_redirect #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect_valid,
  input  logic [fetch_pkg::PC_W-1:0]  redirect_pc,
  input  logic                        stall,
  input  logic                        halt_req,
  ifetch_redirect_if.master           imem,
  output logic                        valid_FD,
  output logic [fetch_pkg::INSTR_W-1:0] instruction_FD,
  output logic [fetch_pkg::PC_W-1:0]  pc_FD,
  output logic [fetch_pkg::PC_W-1:0]  nextPc_FD,
  output logic                        halted
);
  import fetch_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;
  logic               drop_q, drop_d;
  logic               hpend_q, hpend_d;

  logic               fd_vld_q;
  logic [INSTR_W-1:0] fd_instr_q;
  logic [PC_W-1:0]    fd_pc_q, fd_npc_q;

  logic               cpl, pending;
  logic               fd_load, fd_from_skid, fd_clear;
  logic               skid_load, skid_clear, skid_vld;
  logic [INSTR_W-1:0] skid_instr, fd_src_instr;
  logic [PC_W-1:0]    skid_pc, fd_src_pc;

  assign cpl     = imem.imem_req & imem.imem_rvalid;
  assign pending = (state_q == ST_REQ) & ~cpl;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    drop_d       = drop_q;
    hpend_d      = hpend_q;
    fd_load      = 1'b0;
    fd_from_skid = 1'b0;
    fd_clear     = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (state_q == ST_HALT) begin
      fd_clear = 1'b1;
    end else if (hpend_q) begin
      // Halt is waiting for an in-flight fetch; its data is thrown away.
      if (cpl) begin
        state_d = ST_HALT;
        hpend_d = 1'b0;
      end
    end else if (halt_req) begin
      fd_clear   = 1'b1;
      skid_clear = 1'b1;
      drop_d     = 1'b0;
      if (pending) hpend_d = 1'b1;
      else         state_d = ST_HALT;
    end else if (redirect_valid) begin
      fd_clear   = 1'b1;
      skid_clear = 1'b1;
      // An in-flight request keeps its address; remember the target instead.
      if (pending) begin
        drop_d = 1'b1;
        tgt_d  = redirect_pc;
      end else begin
        drop_d  = 1'b0;
        pc_d    = redirect_pc;
        state_d = ST_REQ;
      end
    end else begin
      fd_clear = ~stall;
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (cpl && drop_q) begin
            drop_d = 1'b0;
            pc_d   = tgt_q;
          end else if (cpl) begin
            pc_d = pc_next(pc_q);
            if (!fd_vld_q || !stall) begin
              fd_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_BUF;
            end
          end
        end
        ST_BUF: begin
          if (!stall) begin
            fd_load      = 1'b1;
            fd_from_skid = 1'b1;
            skid_clear   = 1'b1;
            state_d      = ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      drop_q  <= 1'b0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      hpend_q <= hpend_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem.imem_rdata),
    .pc_i    (pc_q),
    .valid_o (skid_vld),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  assign fd_src_instr = fd_from_skid ? skid_instr : imem.imem_rdata;
  assign fd_src_pc    = fd_from_skid ? skid_pc    : pc_q;

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_vld_q   <= 1'b0;
      fd_instr_q <= NOP_INSTR;
      fd_pc_q    <= '0;
      fd_npc_q   <= '0;
    end else if (fd_load) begin
      fd_vld_q   <= fd_from_skid ? skid_vld : 1'b1;
      fd_instr_q <= fd_src_instr;
      fd_pc_q    <= fd_src_pc;
      fd_npc_q   <= pc_next(fd_src_pc);
    end else if (fd_clear) begin
      fd_vld_q <= 1'b0;
    end
  end

  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = pc_q;

  assign valid_FD       = fd_vld_q;
  assign instruction_FD = fd_vld_q ? fd_instr_q : NOP_INSTR;
  assign pc_FD          = fd_pc_q;
  assign nextPc_FD      = fd_npc_q;
  assign halted         = (state_q == ST_HALT);

endmodule
